// File: rtl/csr_unit.sv
// Machine-mode CSR file: trap/mret sequencing, interrupt synchronisation and
// priority, cycle/instret/hpm counters. CSR read and trap redirect are combinational.
module csr_unit #(
  parameter int CNT_W   = 64,
  parameter int NUM_HPM = 2,
  parameter bit VEC_EN  = 1'b1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  csr_access,
  input  logic [2:0]                            csr_funct3,
  input  logic [11:0]                           csr_addr,
  input  logic [31:0]                           csr_src,
  output logic [31:0]                           csr_rdata,
  output logic                                  csr_illegal,
  input  logic                                  exc_valid,
  input  logic [3:0]                            exc_cause,
  input  logic [31:0]                           exc_pc,
  input  logic [31:0]                           exc_tval,
  input  logic                                  int_ok,
  input  logic [31:0]                           int_pc,
  input  logic                                  do_mret,
  input  logic                                  irq_ext,
  input  logic                                  irq_timer,
  input  logic                                  irq_soft,
  input  logic                                  instret_inc,
  input  logic [((NUM_HPM > 0) ? NUM_HPM : 1)-1:0] hpm_event,
  output logic                                  trap_valid,
  output logic [31:0]                           trap_pc,
  output logic [31:0]                           mepc_out
);
  localparam int NCNT = 2 + NUM_HPM;
  localparam logic [31:0] MSTATUS_M = 32'h0000_1888;
  localparam logic [31:0] MIE_M     = 32'h0000_0888;
  localparam logic [31:0] MCINH_M   = 32'h0000_0005 | (((32'd1 << NUM_HPM) - 32'd1) << 3);

  logic [31:0] mstatus_q, mstatus_d, mie_q, mie_d, mtvec_q, mtvec_d, mcinh_q, mcinh_d;
  logic [31:0] mscratch_q, mscratch_d, mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d;
  logic [2:0]  sync1_q, sync1_d, sync2_q, sync2_d;
  logic [CNT_W-1:0] cnt_q [NCNT];
  logic [CNT_W-1:0] cnt_d [NCNT];
  logic [NCNT-1:0]  cnt_inc, cnt_inh;

  logic [31:0] mip, rd_val, wdata, irq_en, trap_base;
  logic        impl, cnt_hit, csr_we, csr_wr, int_pend;
  logic        take_exc, take_int, take_mret, trap_take;
  logic [3:0]  cnt_k, int_cause;
  logic [1:0]  op;
  logic        unused;

  // Counter index -> low 7 address bits: mcycle 0, minstret 2, hpm i at 3+i.
  function automatic logic [6:0] cnt_num(input int k);
    if (k == 0) return 7'd0;
    if (k == 1) return 7'd2;
    return 7'(k + 1);
  endfunction

  assign mip    = {20'd0, sync2_q[2], 3'd0, sync2_q[1], 3'd0, sync2_q[0], 3'd0};
  assign unused = csr_funct3[2] ^ (^hpm_event);

  always_comb begin
    impl    = 1'b0;
    cnt_hit = 1'b0;
    cnt_k   = '0;
    rd_val  = '0;
    case (csr_addr)
      12'h300: begin impl = 1'b1; rd_val = mstatus_q;  end
      12'h304: begin impl = 1'b1; rd_val = mie_q;      end
      12'h305: begin impl = 1'b1; rd_val = mtvec_q;    end
      12'h320: begin impl = 1'b1; rd_val = mcinh_q;    end
      12'h340: begin impl = 1'b1; rd_val = mscratch_q; end
      12'h341: begin impl = 1'b1; rd_val = mepc_q;     end
      12'h342: begin impl = 1'b1; rd_val = mcause_q;   end
      12'h343: begin impl = 1'b1; rd_val = mtval_q;    end
      12'h344: begin impl = 1'b1; rd_val = mip;        end
      default: begin
        if (csr_addr[11:8] == 4'hB || csr_addr[11:8] == 4'hC) begin
          for (int k = 0; k < NCNT; k++) begin
            if (csr_addr[6:0] == cnt_num(k)) begin
              impl    = 1'b1;
              cnt_hit = 1'b1;
              cnt_k   = 4'(k);
              rd_val  = csr_addr[7] ? 32'(cnt_q[k] >> 32) : cnt_q[k][31:0];
            end
          end
        end
      end
    endcase
  end

  assign op          = csr_funct3[1:0];
  assign csr_we      = csr_access && (op != 2'b00) && (op == 2'b01 || csr_src != 32'd0);
  assign csr_illegal = csr_access && (!impl || (csr_addr[11:10] == 2'b11 && csr_we));
  assign csr_rdata   = csr_illegal ? 32'd0 : rd_val;

  always_comb begin
    case (op)
      2'b01:   wdata = csr_src;
      2'b10:   wdata = rd_val | csr_src;
      2'b11:   wdata = rd_val & ~csr_src;
      default: wdata = rd_val;
    endcase
  end

  assign irq_en    = mip & mie_q;
  assign int_pend  = mstatus_q[3] && (irq_en != 32'd0);
  assign int_cause = irq_en[11] ? 4'd11 : (irq_en[3] ? 4'd3 : 4'd7);
  assign take_exc  = exc_valid;
  assign take_int  = !exc_valid && int_pend && int_ok;
  assign take_mret = !exc_valid && !(int_pend && int_ok) && do_mret;
  assign trap_take = take_exc || take_int || take_mret;
  assign trap_base = {mtvec_q[31:2], 2'b00};
  assign csr_wr    = csr_we && !csr_illegal && !trap_take;

  assign trap_valid = trap_take && !rst;
  assign trap_pc    = take_mret ? mepc_q :
                      (take_int && VEC_EN && mtvec_q[0]) ? trap_base + {26'd0, int_cause, 2'b00} :
                      trap_base;
  assign mepc_out   = mepc_q;

  always_comb begin
    cnt_inc    = '0;
    cnt_inh    = '0;
    cnt_inc[0] = 1'b1;
    cnt_inh[0] = mcinh_q[0];
    cnt_inc[1] = instret_inc;
    cnt_inh[1] = mcinh_q[2];
    for (int i = 0; i < NUM_HPM; i++) begin
      cnt_inc[2+i] = hpm_event[i];
      cnt_inh[2+i] = mcinh_q[3+i];
    end
  end

  always_comb begin
    mstatus_d  = mstatus_q;
    mie_d      = mie_q;
    mtvec_d    = mtvec_q;
    mcinh_d    = mcinh_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
    sync1_d    = {irq_ext, irq_timer, irq_soft};
    sync2_d    = sync1_q;
    for (int k = 0; k < NCNT; k++) begin
      cnt_d[k] = cnt_q[k];
      // A write to either half replaces this cycle's increment.
      if (csr_wr && cnt_hit && cnt_k == 4'(k)) begin
        if (csr_addr[7]) cnt_d[k][CNT_W-1:32] = wdata[CNT_W-33:0];
        else             cnt_d[k][31:0]       = wdata;
      end else if (cnt_inc[k] && !cnt_inh[k]) begin
        cnt_d[k] = cnt_q[k] + CNT_W'(1);
      end
    end
    if (csr_wr) begin
      case (csr_addr)
        12'h300: mstatus_d  = wdata & MSTATUS_M;
        12'h304: mie_d      = wdata & MIE_M;
        12'h305: mtvec_d    = VEC_EN ? wdata : {wdata[31:2], 2'b00};
        12'h320: mcinh_d    = wdata & MCINH_M;
        12'h340: mscratch_d = wdata;
        12'h341: mepc_d     = {wdata[31:2], 2'b00};
        12'h342: mcause_d   = wdata;
        12'h343: mtval_d    = wdata;
        default: ;
      endcase
    end
    if (take_exc || take_int) begin
      mepc_d    = take_exc ? {exc_pc[31:2], 2'b00} : {int_pc[31:2], 2'b00};
      mcause_d  = take_exc ? {28'd0, exc_cause} : {1'b1, 27'd0, int_cause};
      mtval_d   = take_exc ? exc_tval : 32'd0;
      mstatus_d = {19'd0, 2'b11, 3'd0, mstatus_q[3], 7'd0};
    end else if (take_mret) begin
      mstatus_d = {19'd0, 2'b00, 3'd0, 1'b1, 3'd0, mstatus_q[7], 3'd0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mstatus_q  <= '0;
      mie_q      <= '0;
      mtvec_q    <= '0;
      mcinh_q    <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      for (int k = 0; k < NCNT; k++) cnt_q[k] <= '0;
    end else begin
      mstatus_q  <= mstatus_d;
      mie_q      <= mie_d;
      mtvec_q    <= mtvec_d;
      mcinh_q    <= mcinh_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      for (int k = 0; k < NCNT; k++) cnt_q[k] <= cnt_d[k];
    end
  end
endmodule

// File: doc/csr_unit.md
CSR_UNIT -- requirements
Module: csr_unit

Interface
REQ-001 Parameter CNT_W, default 64, legal 33..64: width of the mcycle, minstret and mhpmcounter counters.
REQ-002 Parameter NUM_HPM, default 2, legal 0..8: number of hardware event counters, mapped at 0xB03+i (machine) and 0xC03+i (user read-only shadow).
REQ-003 Parameter VEC_EN, default 1: 1 enables vectored mtvec mode; 0 forces mtvec[1:0] to read as 0.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 csr_access  in  1  a CSR instruction commits this cycle.
REQ-007 csr_funct3  in  3  CSR op: 001/101 RW, 010/110 RS, 011/111 RC.
REQ-008 csr_addr  in  12  CSR address.
REQ-009 csr_src  in  32  rs1 value or zero-extended immediate.
REQ-010 csr_rdata  out  32  combinational old value of the CSR.
REQ-011 csr_illegal  out  1  combinational: access is illegal, no write performed.
REQ-012 exc_valid / exc_cause[3:0] / exc_pc[31:0] / exc_tval[31:0]  in  synchronous exception request with its cause, PC and tval.
REQ-013 int_ok  in  1  pipeline can accept an interrupt this cycle; int_pc[31:0] in: PC saved to mepc for an interrupt.
REQ-014 do_mret  in  1  mret commits.
REQ-015 irq_ext, irq_timer, irq_soft  in  1 each  asynchronous interrupt lines.
REQ-016 instret_inc  in  1; hpm_event  in  NUM_HPM (minimum 1 bit): counter increment strobes.
REQ-017 trap_valid  out  1; trap_pc  out  32; mepc_out  out  32: redirect request, redirect target, current mepc.

Function
REQ-018 Implemented CSRs: mstatus 0x300 (only bits 3, 7, 12:11 stored, others read 0), mie 0x304 (bits 3, 7, 11), mtvec 0x305, mcountinhibit 0x320, mscratch 0x340, mepc 0x341 (bits 1:0 read 0), mcause 0x342, mtval 0x343, mip 0x344, mcycle 0xB00/0xB80, minstret 0xB02/0xB82, hpm 0xB03+i/0xB83+i, plus read-only shadows 0xC00/0xC80/0xC02/0xC82/0xC03+i/0xC83+i.
REQ-019 Write enable = csr_access AND (RW OR csr_src != 0); RS new = old | src; RC new = old & ~src.
REQ-020 csr_illegal = csr_access AND (address unimplemented OR (addr[11:10]==2'b11 AND write enable)); when asserted, csr_rdata = 0 and no state changes.
REQ-021 Each counter high half reads counter[CNT_W-1:32] zero-extended to 32 bits; writes to a high half keep only the low CNT_W-32 bits.
REQ-022 Counters wrap modulo 2^CNT_W; mcycle increments every cycle unless mcountinhibit[0]; minstret on instret_inc unless [2]; hpm i on hpm_event[i] unless [3+i]; uninhibitable bits read 0.
REQ-023 A CSR write to a counter half in the same cycle as its increment wins; the increment for that cycle is lost.
REQ-024 irq_ext, irq_timer, irq_soft each pass through a 2-flop synchronizer; mip bits 11/7/3 reflect the synchronized values; mip is read-only and writes to it are ignored without raising csr_illegal.
REQ-025 int_pend = mstatus[3] AND |(mip & mie); selected cause priority 11 > 3 > 7.
REQ-026 Trap priority: exc_valid > (int_pend AND int_ok) > do_mret; at most one acts per cycle.
REQ-027 Exception: trap_valid = 1; next edge mepc <= exc_pc, mcause <= {0, exc_cause}, mtval <= exc_tval, MPIE <= MIE, MIE <= 0, MPP <= 2'b11.
REQ-028 Interrupt: same state update as REQ-027 with mepc <= int_pc, mcause <= {1, cause}, mtval <= 0.
REQ-029 trap_pc = {mtvec[31:2], 00}; when VEC_EN = 1, mtvec[0] = 1 and the trap is an interrupt, trap_pc = base + 4*cause.
REQ-030 mret: trap_valid = 1, trap_pc = mepc; next edge MIE <= MPIE, MPIE <= 1, MPP <= 2'b00.
REQ-031 Trap and CSR write in the same cycle: trap updates of mstatus/mepc/mcause/mtval win; the CSR write is dropped entirely.
REQ-032 trap_valid and trap_pc are combinational; trap_valid is never asserted without exc_valid, (int_pend AND int_ok) or do_mret.

Reset
REQ-033 On rst all CSRs, counters and synchronizer flops are 0 immediately (asynchronous); trap_valid = 0; mepc_out = 0; csr_illegal = 0 unless csr_access is asserted.
REQ-034 Deassertion of rst is taken synchronously; the first mcycle increment occurs on the first edge after release.

Verification
REQ-035 Write mtvec = 0x100 (RW), set mie = 0x80, set mstatus = 0x8, pulse irq_timer with int_ok = 1 -> trap_valid 2 cycles after the pulse (synchronizer latency), trap_pc = 0x100, mcause = 0x80000007, mstatus[3] = 0, mstatus[7] = 1.
REQ-036 mtvec = 0x101, VEC_EN = 1, irq_ext and irq_soft both pending -> cause 11 taken, trap_pc = 0x12C; exception in the same cycle -> exception taken instead, trap_pc = 0x100.
REQ-037 CNT_W = 40: write mcycle high half = 0xFF, low half = 0xFFFFFFFF -> wraps to 0; reading 0xC80 returns 0; write in an increment cycle -> written value held.
REQ-038 CSRRS with csr_src = 0 to 0xC00 -> no illegal, value read; CSRRW to 0xC00 -> csr_illegal = 1; access to 0x7C0 -> csr_illegal = 1, csr_rdata = 0.
REQ-039 Exception with exc_pc = 0x80, then mret -> trap_pc = 0x80, MIE restored, MPP = 0; assert rst mid-trap -> all outputs 0 without waiting for a clock edge.
